// File: rtl/bram_com_ctrl_if.sv
// bram_com_ctrl_if: EPP host pins and the shared BRAM port bundled for bram_com_ctrl.
interface bram_com_ctrl_if #(parameter int ADDR_W = 12, parameter int DATA_W = 8);
  logic stbData, stbAddr, ctrlWr;
  logic [DATA_W-1:0] busEppIn, busEppOut, busEppAddrIn;
  logic [DATA_W-1:0] busBramIn, busBramOut;
  logic [ADDR_W-1:0] busBramAddr;
  logic ctrlWeBram, clkBram, stmBusy;
  modport master (
    output stbData, stbAddr, ctrlWr, busEppIn, busEppAddrIn, busBramIn, stmBusy,
    input  busEppOut, busBramAddr, busBramOut, ctrlWeBram, clkBram
  );
  modport slave (
    input  stbData, stbAddr, ctrlWr, busEppIn, busEppAddrIn, busBramIn, stmBusy,
    output busEppOut, busBramAddr, busBramOut, ctrlWeBram, clkBram
  );
endinterface

// File: rtl/bram_com_ctrl.sv
// bram_com_ctrl: EPP register file (pointer, auto-increment data port, status) bridging to a shared BRAM.
// Define EXT_ADDR_EN to select data registers from busEppAddrIn instead of the address register.
module bram_com_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rstN,
  bram_com_ctrl_if.slave bus
);
  localparam logic [DATA_W-1:0] PTR_LO = 'h0, PTR_HI = 'h1, REG_DATA = 'h2, STATUS = 'h3;
  logic [2:0] syncData, syncAddr;
  logic [1:0] syncWr, warm;
  logic armData, armAddr, rdPend;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regSel, sel, rdData;
  logic dataFall, dataRise, addrFall, hostWr;
`ifdef EXT_ADDR_EN
  assign sel = bus.busEppAddrIn;
`else
  logic unusedExtSel;
  assign unusedExtSel = ^bus.busEppAddrIn;
  assign sel = regSel;
`endif
  // Strobes must be seen high after reset before a fall counts, so a strobe held across reset is ignored.
  assign addrFall = armAddr & syncAddr[2] & ~syncAddr[1];
  assign dataFall = armData & syncData[2] & ~syncData[1] & syncAddr[1];
  assign dataRise = ~syncData[2] & syncData[1];
  assign hostWr = ~syncWr[1];
  assign bus.busBramAddr = ptr;
  assign bus.clkBram = clk;
  always_comb begin
    rdData = sel == PTR_LO   ? ptr[DATA_W-1:0] :
             sel == PTR_HI   ? DATA_W'(ptr[ADDR_W-1:DATA_W]) :
             sel == REG_DATA ? (bus.stmBusy ? '1 : bus.busBramIn) :
             sel == STATUS   ? DATA_W'(bus.stmBusy) : '0;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncData <= '1;
      syncAddr <= '1;
      syncWr <= '1;
      warm <= '0;
      armData <= 1'b0;
      armAddr <= 1'b0;
      rdPend <= 1'b0;
      ptr <= '0;
      regSel <= '0;
      bus.busEppOut <= '0;
      bus.busBramOut <= '0;
      bus.ctrlWeBram <= 1'b0;
    end else begin
      syncData <= {syncData[1:0], bus.stbData};
      syncAddr <= {syncAddr[1:0], bus.stbAddr};
      syncWr <= {syncWr[0], bus.ctrlWr};
      warm <= {warm[0], 1'b1};
      armData <= armData | (warm[1] & syncData[1]);
      armAddr <= armAddr | (warm[1] & syncAddr[1]);
      bus.ctrlWeBram <= 1'b0;
      if (bus.ctrlWeBram || (dataRise && rdPend && !bus.stmBusy)) ptr <= ptr + 1'b1;
      if (dataRise) rdPend <= 1'b0;
      if (addrFall && hostWr) regSel <= bus.busEppIn;
      if (addrFall && !hostWr) bus.busEppOut <= regSel;
      if (dataFall && !hostWr) begin
        bus.busEppOut <= rdData;
        rdPend <= sel == REG_DATA && !bus.stmBusy;
      end
      if (dataFall && hostWr) begin
        if (sel == PTR_LO) ptr[DATA_W-1:0] <= bus.busEppIn;
        if (sel == PTR_HI) ptr[ADDR_W-1:DATA_W] <= bus.busEppIn[ADDR_W-DATA_W-1:0];
        if (sel == REG_DATA && !bus.stmBusy) begin
          bus.busBramOut <= bus.busEppIn;
          bus.ctrlWeBram <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bram_com_ctrl.sv
// tb_bram_com_ctrl: scoreboard bench for bram_com_ctrl with a 4096x8 synchronous BRAM model.
module tb_bram_com_ctrl;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int vecs = 0;
  int errs = 0;
  logic [19:0] weQ[$];
  logic [7:0] rdQ[$];
  logic [19:0] weExp;
  logic [7:0] mem [4096];
  bram_com_ctrl_if bus();
  bram_com_ctrl dut(.clk(clk), .rstN(rstN), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge bus.clkBram) begin
    if (bus.ctrlWeBram) mem[bus.busBramAddr] <= bus.busBramOut;
    bus.busBramIn <= mem[bus.busBramAddr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Every write-enable pulse must match the next queued write, at its address and data.
  always @(negedge clk) begin
    if (rstN && bus.ctrlWeBram) begin
      if (weQ.size() == 0) chk("weUnexpected", 1, 0);
      else begin
        weExp = weQ.pop_front();
        chk("weAddr", bus.busBramAddr, weExp[19:8]);
        chk("weData", bus.busBramOut, weExp[7:0]);
      end
    end
  end
  task automatic epp(input bit isAddr, input bit rd, input logic [7:0] d);
    bus.ctrlWr = rd;
    bus.busEppIn = d;
    @(negedge clk);
    if (isAddr) bus.stbAddr = 1'b0;
    else bus.stbData = 1'b0;
    repeat (5) @(negedge clk);
    bus.stbAddr = 1'b1;
    bus.stbData = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic setSel(input logic [7:0] s);
    bus.busEppAddrIn = s;
    epp(1'b1, 1'b0, s);
  endtask
  task automatic wrData(input logic [7:0] d);
    epp(1'b0, 1'b0, d);
  endtask
  task automatic wrBram(input logic [11:0] a, input logic [7:0] d);
    weQ.push_back({a, d});
    wrData(d);
  endtask
  task automatic rdExp(input string tag, input bit isAddr, input logic [7:0] exp);
    rdQ.push_back(exp);
    epp(isAddr, 1'b1, 8'h00);
    chk(tag, bus.busEppOut, rdQ.pop_front());
  endtask
  initial begin
    bus.stbData = 1'b1;
    bus.stbAddr = 1'b1;
    bus.ctrlWr = 1'b1;
    bus.busEppIn = 8'h00;
    bus.busEppAddrIn = 8'h00;
    bus.stmBusy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstEppOut", bus.busEppOut, 8'h00);
    chk("rstBramAddr", bus.busBramAddr, 12'h000);
    chk("rstBramOut", bus.busBramOut, 8'h00);
    chk("rstWe", bus.ctrlWeBram, 1'b0);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    chk("postRstAddr", bus.busBramAddr, 12'h000);
    chk("clkBram", bus.clkBram, clk);
    setSel(8'h55);
    rdExp("selReadback", 1'b1, 8'h55);
    wrData(8'h44);
    chk("unmapPtr", bus.busBramAddr, 12'h000);
    chk("unmapBramOut", bus.busBramOut, 8'h00);
    rdExp("unmapRead", 1'b0, 8'h00);
    setSel(8'h00);
    wrData(8'hFF);
    setSel(8'h01);
    wrData(8'h0F);
    chk("ptrFFF", bus.busBramAddr, 12'hFFF);
    rdExp("ptrHiRead", 1'b0, 8'h0F);
    setSel(8'h02);
    wrBram(12'hFFF, 8'h44);
    chk("ptrWrap", bus.busBramAddr, 12'h000);
    chk("bramOut44", bus.busBramOut, 8'h44);
    setSel(8'h00);
    wrData(8'h10);
    setSel(8'h01);
    wrData(8'h00);
    setSel(8'h02);
    wrBram(12'h010, 8'hA5);
    wrBram(12'h011, 8'h3C);
    chk("ptr012", bus.busBramAddr, 12'h012);
    setSel(8'h00);
    wrData(8'h10);
    rdExp("ptrLoRead", 1'b0, 8'h10);
    setSel(8'h02);
    rdExp("bramReadA5", 1'b0, 8'hA5);
    chk("rdIncr011", bus.busBramAddr, 12'h011);
    rdExp("bramRead3C", 1'b0, 8'h3C);
    chk("rdIncr012", bus.busBramAddr, 12'h012);
    bus.stmBusy = 1'b1;
    wrData(8'h12);
    chk("busyPtr", bus.busBramAddr, 12'h012);
    chk("busyBramOut", bus.busBramOut, 8'h3C);
    rdExp("busyRead", 1'b0, 8'hFF);
    chk("busyRdPtr", bus.busBramAddr, 12'h012);
    setSel(8'h03);
    rdExp("statusBusy", 1'b0, 8'h01);
    bus.stmBusy = 1'b0;
    rdExp("statusIdle", 1'b0, 8'h00);
    setSel(8'h00);
    bus.ctrlWr = 1'b0;
    bus.busEppIn = 8'h02;
    @(negedge clk);
    bus.stbAddr = 1'b0;
    bus.stbData = 1'b0;
    repeat (5) @(negedge clk);
    bus.stbAddr = 1'b1;
    bus.stbData = 1'b1;
    repeat (5) @(negedge clk);
    chk("bothPtr", bus.busBramAddr, 12'h012);
    rdExp("bothSel", 1'b1, 8'h02);
    setSel(8'h00);
    bus.busEppAddrIn = 8'h02;
`ifdef EXT_ADDR_EN
    wrBram(12'h012, 8'h33);
    chk("extSelPtr", bus.busBramAddr, 12'h013);
`else
    wrData(8'h33);
    chk("extSelPtr", bus.busBramAddr, 12'h033);
`endif
    bus.busEppAddrIn = 8'h00;
    bus.ctrlWr = 1'b0;
    bus.busEppIn = 8'h77;
    @(negedge clk);
    bus.stbData = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    chk("midRstPtr", bus.busBramAddr, 12'h000);
    rstN = 1'b1;
    repeat (6) @(negedge clk);
    bus.stbData = 1'b1;
    repeat (5) @(negedge clk);
    chk("heldStrobeIgnored", bus.busBramAddr, 12'h000);
    wrData(8'h21);
    chk("postRstWrite", bus.busBramAddr, 12'h021);
    chk("weDrained", weQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
